mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute stage. It consumes `ex_stage_reg` and issues at most one data-memory request per instruction over a pulse-request / response handshake. Load data is aligned and sign/zero-extended, and stores get byte masks. The stage stalls the pipeline until the response returns, then latches `mem_stage_reg` for writeback.

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one data-memory request per instruction,
// stalls until the response returns, then latches the aligned/extended result.
package rv32imc_types;
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] func_out;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } ex_stage_t;

    typedef struct packed {
        logic [31:0] func_out;
        logic [31:0] load_data;
        logic [4:0]  rd_addr;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } mem_stage_t;
endpackage

module mem_stage
    import rv32imc_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    output logic        o_mem_stall,
    input  ex_stage_t   ex_stage_reg,
    output mem_stage_t  mem_stage_reg,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_mem_op;
    logic [1:0]  w_off;
    logic [3:0]  w_mask;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_issue;
    logic        w_advance;
    logic [31:0] w_rdata_src;
    mem_stage_t  w_mem_next;

    logic [31:0] r_addr;
    logic [3:0]  r_rmask;
    logic [3:0]  r_wmask;
    logic [31:0] r_wdata;
    logic [31:0] r_hold_rdata;

    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [31:0] rdata,
                                                input logic [1:0]  off);
        logic [31:0] raw;
        raw = rdata >> {off, 3'b000};
        case (funct3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always_comb begin
        w_mem_op = ex_stage_reg.rvfi.valid &
                   (ex_stage_reg.mem_ctrl.mem_read | ex_stage_reg.mem_ctrl.mem_write);
        w_off    = ex_stage_reg.func_out[1:0];
        w_addr   = {ex_stage_reg.func_out[31:2], 2'b00};
        w_wdata  = ex_stage_reg.rs2_rdata << {w_off, 3'b000};
        // Lanes shifted past byte 3 fall off the 4-bit mask; misalignment is not trapped.
        case (ex_stage_reg.mem_ctrl.funct3[1:0])
            2'b00:   w_mask = 4'b0001 << w_off;
            2'b01:   w_mask = 4'b0011 << w_off;
            default: w_mask = 4'b1111;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        dmem_addr    = '0;
        dmem_rmask   = '0;
        dmem_wmask   = '0;
        dmem_wdata   = '0;
        o_mem_stall  = w_mem_op & ((r_state == IDLE) | ((r_state == WAIT) & !dmem_resp));
        case (r_state)
            IDLE: begin
                if (w_mem_op && !rst) begin
                    w_issue      = 1'b1;
                    w_state_next = WAIT;
                    dmem_addr    = w_addr;
                    dmem_rmask   = ex_stage_reg.mem_ctrl.mem_read  ? w_mask : 4'b0000;
                    dmem_wmask   = ex_stage_reg.mem_ctrl.mem_write ? w_mask : 4'b0000;
                    dmem_wdata   = ex_stage_reg.mem_ctrl.mem_write ? w_wdata : 32'h0;
                end
            end
            WAIT: begin
                if (dmem_resp) w_state_next = i_stall ? DONE : IDLE;
            end
            DONE: begin
                if (!i_stall) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        w_advance = !o_mem_stall & !i_stall;
    end

    always_comb begin
        w_rdata_src          = (r_state == DONE) ? r_hold_rdata : dmem_rdata;
        w_mem_next           = '0;
        w_mem_next.func_out  = ex_stage_reg.func_out;
        w_mem_next.rd_addr   = ex_stage_reg.rd_addr;
        w_mem_next.wb_ctrl   = ex_stage_reg.wb_ctrl;
        w_mem_next.rvfi      = ex_stage_reg.rvfi;
        if (w_mem_op) begin
            if (ex_stage_reg.mem_ctrl.mem_read)
                w_mem_next.load_data = load_extend(ex_stage_reg.mem_ctrl.funct3, w_rdata_src, w_off);
            w_mem_next.rvfi.mem_addr  = r_addr;
            w_mem_next.rvfi.mem_rmask = r_rmask;
            w_mem_next.rvfi.mem_wmask = r_wmask;
            w_mem_next.rvfi.mem_rdata = w_rdata_src;
            w_mem_next.rvfi.mem_wdata = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Issue-time request is kept so the retirement record reports what was sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_rmask <= '0;
            r_wmask <= '0;
            r_wdata <= '0;
        end else if (w_issue) begin
            r_addr  <= dmem_addr;
            r_rmask <= dmem_rmask;
            r_wmask <= dmem_wmask;
            r_wdata <= dmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                              r_hold_rdata <= '0;
        else if ((r_state == WAIT) && dmem_resp && i_stall)  r_hold_rdata <= dmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst)            mem_stage_reg <= '0;
        else if (w_advance) mem_stage_reg <= w_mem_next;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores, alignment, delayed and held responses,
// reset during an outstanding access and back-to-back instruction flow.
module tb_mem_stage;
    import rv32imc_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall;
    logic        o_mem_stall;
    ex_stage_t   ex;
    mem_stage_t  ms;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    int n_vec = 0;
    int n_err = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .o_mem_stall(o_mem_stall),
        .ex_stage_reg(ex), .mem_stage_reg(ms),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    function automatic ex_stage_t mk_ex(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] rs2,
                                        input logic [4:0] rd);
        ex_stage_t e;
        e = '0;
        e.func_out           = addr;
        e.rs2_rdata          = rs2;
        e.rd_addr            = rd;
        e.mem_ctrl.mem_read  = rd_en;
        e.mem_ctrl.mem_write = wr_en;
        e.mem_ctrl.funct3    = f3;
        e.wb_ctrl.reg_write  = !wr_en;
        e.rvfi.valid         = 1'b1;
        e.rvfi.inst          = 32'h0000_0013;
        e.rvfi.pc_rdata      = 32'h0000_0400;
        return e;
    endfunction

    // Upstream/memory model: presents one instruction, answers k cycles after issue,
    // holds i_stall for the response cycle plus 'hold' more, returns after it advances.
    task automatic run_op(input ex_stage_t e, input int k, input logic [31:0] rdat, input int hold,
                          output int stalls, output int issues, output logic [3:0] rm,
                          output logic [3:0] wm, output logic [31:0] ad, output logic [31:0] wd);
        logic adv;
        bit   done;
        stalls = 0; issues = 0; rm = '0; wm = '0; ad = '0; wd = '0; done = 0;
        ex = e; dmem_resp = 1'b0; i_stall = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (o_mem_stall) stalls++;
            if (dmem_rmask != 4'b0 || dmem_wmask != 4'b0) begin
                issues++; rm = dmem_rmask; wm = dmem_wmask; ad = dmem_addr; wd = dmem_wdata;
            end
            adv = !o_mem_stall && !i_stall;
            @(posedge clk); #1;
            if (adv) done = 1;
            else begin
                dmem_resp  = (c + 1 == k);
                dmem_rdata = (c + 1 == k) ? rdat : 32'hBAD0_BAD0;
                i_stall    = (hold > 0) && (c + 1 >= k) && (c + 1 <= k + hold);
            end
        end
        dmem_resp = 1'b0; i_stall = 1'b0; ex = '0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL run_op_timeout: got no advance within 60 cycles, want advance");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ex = '0; i_stall = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (o_mem_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", o_mem_stall); end
        n_vec++; if (dmem_rmask !== 4'b0) begin n_err++; $display("FAIL rst_rmask: got %b want 0000", dmem_rmask); end
        n_vec++; if (dmem_wmask !== 4'b0) begin n_err++; $display("FAIL rst_wmask: got %b want 0000", dmem_wmask); end
        n_vec++; if (dmem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", dmem_addr); end
        n_vec++; if (dmem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", dmem_wdata); end
        n_vec++; if (ms !== '0) begin n_err++; $display("FAIL rst_mem_stage_reg: got nonzero want 0"); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_lw();
        int s, n; logic [3:0] rm, wm; logic [31:0] ad, wd;
        run_op(mk_ex(1, 0, 3'b010, 32'h1000, 32'h0, 5'd5), 1, 32'hDEAD_BEEF, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (rm !== 4'b1111) begin n_err++; $display("FAIL lw_rmask: got %b want 1111", rm); end
        n_vec++; if (wm !== 4'b0000) begin n_err++; $display("FAIL lw_wmask: got %b want 0000", wm); end
        n_vec++; if (ad !== 32'h1000) begin n_err++; $display("FAIL lw_addr: got %h want 00001000", ad); end
        n_vec++; if (s !== 1) begin n_err++; $display("FAIL lw_stall_cycles: got %0d want 1", s); end
        n_vec++; if (n !== 1) begin n_err++; $display("FAIL lw_issues: got %0d want 1", n); end
        n_vec++; if (ms.load_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_data: got %h want deadbeef", ms.load_data); end
        n_vec++; if (ms.rd_addr !== 5'd5) begin n_err++; $display("FAIL lw_rd: got %0d want 5", ms.rd_addr); end
        n_vec++; if (ms.rvfi.mem_rmask !== 4'b1111) begin n_err++; $display("FAIL lw_rvfi_rmask: got %b want 1111", ms.rvfi.mem_rmask); end
        n_vec++; if (ms.rvfi.mem_addr !== 32'h1000) begin n_err++; $display("FAIL lw_rvfi_addr: got %h want 00001000", ms.rvfi.mem_addr); end
    endtask

    task automatic test_byte_half_loads();
        int s, n; logic [3:0] rm, wm; logic [31:0] ad, wd;
        run_op(mk_ex(1, 0, 3'b000, 32'h1003, 32'h0, 5'd6), 1, 32'h8011_2233, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (rm !== 4'b1000) begin n_err++; $display("FAIL lb_rmask: got %b want 1000", rm); end
        n_vec++; if (ms.load_data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h want ffffff80", ms.load_data); end
        n_vec++; if (ms.rvfi.mem_rdata !== 32'h8011_2233) begin n_err++; $display("FAIL lb_rvfi_rdata: got %h want 80112233", ms.rvfi.mem_rdata); end
        n_vec++; if (ms.rvfi.mem_addr !== 32'h1000) begin n_err++; $display("FAIL lb_rvfi_addr: got %h want 00001000", ms.rvfi.mem_addr); end
        run_op(mk_ex(1, 0, 3'b100, 32'h1003, 32'h0, 5'd6), 1, 32'h8011_2233, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (rm !== 4'b1000) begin n_err++; $display("FAIL lbu_rmask: got %b want 1000", rm); end
        n_vec++; if (ms.load_data !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_data: got %h want 00000080", ms.load_data); end
        run_op(mk_ex(1, 0, 3'b001, 32'h1002, 32'h0, 5'd7), 1, 32'h8001_0000, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (rm !== 4'b1100) begin n_err++; $display("FAIL lh_rmask: got %b want 1100", rm); end
        n_vec++; if (ms.load_data !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_data: got %h want ffff8001", ms.load_data); end
        run_op(mk_ex(1, 0, 3'b101, 32'h1002, 32'h0, 5'd7), 1, 32'h8001_0000, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (ms.load_data !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_data: got %h want 00008001", ms.load_data); end
    endtask

    task automatic test_stores();
        int s, n; logic [3:0] rm, wm; logic [31:0] ad, wd;
        run_op(mk_ex(0, 1, 3'b001, 32'h2002, 32'h0000_ABCD, 5'd0), 1, 32'h0, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (wm !== 4'b1100) begin n_err++; $display("FAIL sh_wmask: got %b want 1100", wm); end
        n_vec++; if (rm !== 4'b0000) begin n_err++; $display("FAIL sh_rmask: got %b want 0000", rm); end
        n_vec++; if (wd !== 32'hABCD_0000) begin n_err++; $display("FAIL sh_wdata: got %h want abcd0000", wd); end
        n_vec++; if (ad !== 32'h2000) begin n_err++; $display("FAIL sh_addr: got %h want 00002000", ad); end
        n_vec++; if (n !== 1) begin n_err++; $display("FAIL sh_pulse: got %0d issue cycles want 1", n); end
        n_vec++; if (ms.rvfi.mem_wdata !== 32'hABCD_0000) begin n_err++; $display("FAIL sh_rvfi_wdata: got %h want abcd0000", ms.rvfi.mem_wdata); end
        n_vec++; if (ms.rvfi.mem_wmask !== 4'b1100) begin n_err++; $display("FAIL sh_rvfi_wmask: got %b want 1100", ms.rvfi.mem_wmask); end
        run_op(mk_ex(0, 1, 3'b001, 32'h2003, 32'h0000_1234, 5'd0), 1, 32'h0, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (wm !== 4'b1000) begin n_err++; $display("FAIL sh_misalign_wmask: got %b want 1000", wm); end
        n_vec++; if (wd !== 32'h3400_0000) begin n_err++; $display("FAIL sh_misalign_wdata: got %h want 34000000", wd); end
        run_op(mk_ex(0, 1, 3'b000, 32'h2001, 32'h0000_0055, 5'd0), 1, 32'h0, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (wm !== 4'b0010) begin n_err++; $display("FAIL sb_wmask: got %b want 0010", wm); end
        n_vec++; if (wd !== 32'h0000_5500) begin n_err++; $display("FAIL sb_wdata: got %h want 00005500", wd); end
    endtask

    task automatic test_delayed_hold();
        int s, n; logic [3:0] rm, wm; logic [31:0] ad, wd;
        run_op(mk_ex(1, 0, 3'b010, 32'h3000, 32'h0, 5'd9), 5, 32'h1234_5678, 2, s, n, rm, wm, ad, wd);
        n_vec++; if (s !== 5) begin n_err++; $display("FAIL hold_stall_cycles: got %0d want 5", s); end
        n_vec++; if (n !== 1) begin n_err++; $display("FAIL hold_reissue: got %0d issue cycles want 1", n); end
        n_vec++; if (ms.load_data !== 32'h1234_5678) begin n_err++; $display("FAIL hold_data: got %h want 12345678", ms.load_data); end
        n_vec++; if (ms.rvfi.mem_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL hold_rvfi_rdata: got %h want 12345678", ms.rvfi.mem_rdata); end
        n_vec++; if (ms.rd_addr !== 5'd9) begin n_err++; $display("FAIL hold_rd: got %0d want 9", ms.rd_addr); end
    endtask

    task automatic test_reset_mid_wait();
        ex = mk_ex(1, 0, 3'b010, 32'h3000, 32'h0, 5'd4); i_stall = 1'b0; dmem_resp = 1'b0;
        @(negedge clk);
        n_vec++; if (dmem_rmask !== 4'b1111) begin n_err++; $display("FAIL rw_issue_rmask: got %b want 1111", dmem_rmask); end
        @(posedge clk); #1;
        rst = 1'b1; ex = '0;
        @(negedge clk);
        n_vec++; if (o_mem_stall !== 1'b0) begin n_err++; $display("FAIL rw_rst_stall: got %b want 0", o_mem_stall); end
        n_vec++; if (dmem_addr !== 32'h0) begin n_err++; $display("FAIL rw_rst_addr: got %h want 0", dmem_addr); end
        @(posedge clk); #1;
        rst = 1'b0; ex = mk_ex(0, 0, 3'b000, 32'h77, 32'h0, 5'd2);
        dmem_resp = 1'b1; dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        n_vec++; if (ms !== '0) begin n_err++; $display("FAIL rw_rst_reg: got nonzero mem_stage_reg want 0"); end
        n_vec++; if (dmem_rmask !== 4'b0 || dmem_wmask !== 4'b0) begin n_err++; $display("FAIL rw_stray_masks: got %b/%b want 0000/0000", dmem_rmask, dmem_wmask); end
        n_vec++; if (o_mem_stall !== 1'b0) begin n_err++; $display("FAIL rw_stray_stall: got %b want 0", o_mem_stall); end
        @(posedge clk); #1;
        dmem_resp = 1'b0; ex = '0;
        n_vec++; if (ms.func_out !== 32'h77) begin n_err++; $display("FAIL rw_pass_func: got %h want 00000077", ms.func_out); end
        n_vec++; if (ms.load_data !== 32'h0) begin n_err++; $display("FAIL rw_stray_latch: got %h want 0", ms.load_data); end
        n_vec++; if (ms.rvfi.mem_rdata !== 32'h0) begin n_err++; $display("FAIL rw_stray_rvfi: got %h want 0", ms.rvfi.mem_rdata); end
    endtask

    task automatic test_back_to_back();
        int s, n; logic [3:0] rm, wm; logic [31:0] ad, wd;
        run_op(mk_ex(0, 0, 3'b000, 32'h11, 32'h0, 5'd3), 1, 32'h0, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (s !== 0) begin n_err++; $display("FAIL b2b_add_stall: got %0d want 0", s); end
        n_vec++; if (n !== 0) begin n_err++; $display("FAIL b2b_add_issue: got %0d want 0", n); end
        n_vec++; if (ms.func_out !== 32'h11 || ms.rd_addr !== 5'd3) begin n_err++; $display("FAIL b2b_add_pass: got %h/%0d want 00000011/3", ms.func_out, ms.rd_addr); end
        n_vec++; if (ms.rvfi.valid !== 1'b1) begin n_err++; $display("FAIL b2b_add_valid: got %b want 1", ms.rvfi.valid); end
        run_op(mk_ex(0, 1, 3'b010, 32'h2004, 32'hCAFE_F00D, 5'd0), 1, 32'h0, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (n !== 1) begin n_err++; $display("FAIL b2b_sw_issue: got %0d want 1", n); end
        n_vec++; if (wm !== 4'b1111 || wd !== 32'hCAFE_F00D) begin n_err++; $display("FAIL b2b_sw_req: got %b/%h want 1111/cafef00d", wm, wd); end
        n_vec++; if (ms.rvfi.mem_wmask !== wm) begin n_err++; $display("FAIL b2b_sw_rvfi_wmask: got %b want %b", ms.rvfi.mem_wmask, wm); end
        run_op(mk_ex(1, 0, 3'b010, 32'h2004, 32'h0, 5'd8), 2, 32'hCAFE_F00D, 0, s, n, rm, wm, ad, wd);
        n_vec++; if (n !== 1) begin n_err++; $display("FAIL b2b_lw_issue: got %0d want 1", n); end
        n_vec++; if (s !== 2) begin n_err++; $display("FAIL b2b_lw_stall: got %0d want 2", s); end
        n_vec++; if (rm !== 4'b1111) begin n_err++; $display("FAIL b2b_lw_rmask: got %b want 1111", rm); end
        n_vec++; if (ms.rvfi.mem_rmask !== rm) begin n_err++; $display("FAIL b2b_lw_rvfi_rmask: got %b want %b", ms.rvfi.mem_rmask, rm); end
        n_vec++; if (ms.load_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL b2b_lw_data: got %h want cafef00d", ms.load_data); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_half_loads();
        test_stores();
        test_delayed_hold();
        test_reset_mid_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
